// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Holds the scan state encoding, segment bit order and hex glyph table.
package seven_seg_pkg;

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } scan_state_t;

  // Segment vectors are {g,f,e,d,c,b,a}: a is bit 0, g is bit 6.
  localparam int SEG_A = 0;
  localparam int SEG_G = 6;

  // Active-high glyphs, indexed by nibble (entry 15 listed first).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seven_segment_hex_decoder.sv
// Hex nibble to active-high {g..a} segment decoder.
// Ports: nibble (4b in), blank (forces all off), seg (7b out).
module seven_segment_hex_decoder
  import seven_seg_pkg::*;
(
  input  logic             [3:0] nibble,
  input  logic                   blank,
  output logic [SEG_G:SEG_A]     seg
);

  always_comb begin
    seg = HEX_SEG[nibble];
    if (blank) seg = '0;
  end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed common-anode seven-segment scan driver.
// Ports: clk, reset (sync, active-high), tick, enable, value_in/dp_in/
// value_valid/value_ready handshake, anode, segment, dp, frame_done.
// Option: SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_segment_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              segment,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int GAP_LEN = (BLANK_CYCLES < 1) ? 1 : BLANK_CYCLES;
  localparam int CW = $clog2(GAP_LEN + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_LEN - 1);
  localparam logic INV = (ACTIVE_LOW != 0);

  scan_state_t state, state_d;
  logic [CW-1:0] gap_cnt, gap_cnt_d;
  logic [IW-1:0] idx, idx_d;
  logic wrap;

  logic tick_q;
  logic tick_rise;

  logic pending_full;
  logic [4*NUM_DIGITS-1:0] pend_val, disp_val;
  logic [NUM_DIGITS-1:0] pend_dp, disp_dp;
  logic xfer;

  logic [3:0] nib;
  logic blank;
  logic [6:0] seg_dec;
  logic [NUM_DIGITS-1:0] sel;

  logic [NUM_DIGITS-1:0] an_r;
  logic [6:0] seg_r;
  logic dp_r;

  assign tick_rise = tick & ~tick_q;

  always_ff @(posedge clk) begin
    if (reset) tick_q <= 1'b0;
    else tick_q <= tick;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= GAP;
      gap_cnt <= '0;
      idx     <= LAST;
    end else begin
      state   <= state_d;
      gap_cnt <= gap_cnt_d;
      idx     <= idx_d;
    end
  end

  // Disable simply freezes the scan; ticks seen meanwhile are dropped.
  always_comb begin
    state_d   = state;
    gap_cnt_d = gap_cnt;
    idx_d     = idx;
    wrap      = 1'b0;
    if (enable) begin
      case (state)
        GAP: begin
          if (gap_cnt == GAP_END) begin
            state_d   = SHOW;
            gap_cnt_d = '0;
            if (idx == LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx + 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt + 1'b1;
          end
        end
        SHOW: begin
          if (tick_rise) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end
        default: state_d = GAP;
      endcase
    end
  end

  // Capture and commit never coincide: capture needs an empty slot,
  // commit needs a full one.
  assign value_ready = ~pending_full;
  assign xfer = value_valid & ~pending_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_full <= 1'b0;
      pend_val     <= '0;
      pend_dp      <= '0;
      disp_val     <= '0;
      disp_dp      <= '0;
    end else if (xfer) begin
      pending_full <= 1'b1;
      pend_val     <= value_in;
      pend_dp      <= dp_in;
    end else if (wrap && pending_full) begin
      pending_full <= 1'b0;
      disp_val     <= pend_val;
      disp_dp      <= pend_dp;
    end
  end

  assign nib = disp_val[{idx, 2'b00} +: 4];
  assign sel = NUM_DIGITS'(1) << idx;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;

  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (disp_val[4*i +: 4] != 4'h0) msd = IW'(i);
    end
  end

  assign blank = (idx > msd);
`else
  assign blank = 1'b0;
`endif

  seven_segment_hex_decoder u_dec (
    .nibble (nib),
    .blank  (blank),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      an_r       <= '0;
      seg_r      <= '0;
      dp_r       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (enable && state == SHOW) begin
        an_r  <= sel;
        seg_r <= seg_dec;
        dp_r  <= disp_dp[idx];
      end else begin
        an_r  <= '0;
        seg_r <= '0;
        dp_r  <= 1'b0;
      end
    end
  end

  assign anode   = INV ? ~an_r : an_r;
  assign segment = INV ? ~seg_r : seg_r;
  assign dp      = INV ? ~dp_r : dp_r;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Self-checking bench for seven_segment_scan_driver.
// NUM_DIGITS=4, BLANK_CYCLES=2, ACTIVE_LOW=1, manual tick.
module tb_seven_segment_scan_driver;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic enable = 1'b1;
  logic [15:0] value_in = '0;
  logic [3:0] dp_in = '0;
  logic value_valid = 1'b0;
  logic value_ready;
  logic [3:0] anode;
  logic [6:0] segment;
  logic dp;
  logic frame_done;

  always #5 clk = ~clk;

  seven_segment_scan_driver #(
    .NUM_DIGITS   (4),
    .BLANK_CYCLES (2),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .enable      (enable),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .anode       (anode),
    .segment     (segment),
    .dp          (dp),
    .frame_done  (frame_done)
  );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZHI = 7'h7F;
`else
  localparam logic [6:0] ZHI = 7'h40;
`endif

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } obs_t;

  typedef struct packed {
    logic [15:0]     val;
    logic [3:0]      dpv;
    logic [3:0][6:0] seg;
  } vec_t;

  obs_t exp_q[$];
  vec_t vecs[4];
  int checks = 0;
  int failures = 0;
  int fd_count = 0;
  logic [3:0] last_an = 4'hF;
  bit mon_en = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic monitor();
    obs_t o;
    obs_t e;
    if (frame_done) fd_count++;
    if (anode !== last_an && anode !== 4'hF) begin
      o = {anode, segment, dp};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scan_unexpected: got %0h expected none", o);
      end else begin
        e = exp_q.pop_front();
        chk("scan_digit", o, e);
      end
    end
    last_an = anode;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (mon_en) monitor();
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic advance();
    tick_pulse();
    steps(5);
  endtask

  task automatic push(logic [3:0] a, logic [6:0] s, logic d);
    exp_q.push_back({a, s, d});
  endtask

  task automatic xfer(logic [15:0] v, logic [3:0] d);
    value_in = v;
    dp_in = d;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
  endtask

  initial begin
    int n;
    int bad;

    vecs[0] = '{16'h3210, 4'b0001,
                {7'h30, 7'h24, 7'h79, 7'h40}};
    vecs[1] = '{16'h7654, 4'b0010,
                {7'h78, 7'h02, 7'h12, 7'h19}};
    vecs[2] = '{16'hBA98, 4'b1000,
                {7'h03, 7'h08, 7'h10, 7'h00}};
    vecs[3] = '{16'hFEDC, 4'b0000,
                {7'h0E, 7'h06, 7'h21, 7'h46}};

    // reset
    steps(2);
    reset = 1'b0;
    chk("rst_anode", anode, 4'hF);
    chk("rst_segment", segment, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_ready", value_ready, 1'b1);
    mon_en = 1'b1;
    push(4'hE, 7'h40, 1'b1);
    steps(3);
    chk("first_anode", anode, 4'hE);
    chk("first_segment", segment, 7'h40);
    chk("first_frame_done", fd_count, 1);
    chk("first_ready", value_ready, 1'b1);

    // mid-frame update: old frame completes first
    xfer(16'h12AF, 4'b0100);
    chk("ready_after_xfer", value_ready, 1'b0);
    push(4'hD, ZHI, 1'b1);
    push(4'hB, ZHI, 1'b1);
    push(4'h7, ZHI, 1'b1);
    for (int i = 0; i < 3; i++) advance();
    chk("ready_pending", value_ready, 1'b0);
    push(4'hE, 7'h0E, 1'b1);
    push(4'hD, 7'h08, 1'b1);
    push(4'hB, 7'h24, 1'b0);
    push(4'h7, 7'h79, 1'b1);
    advance();
    chk("ready_after_commit", value_ready, 1'b1);
    for (int i = 0; i < 3; i++) advance();

    // table-driven glyph sweep, one frame per vector
    for (int v = 0; v < 4; v++) begin
      xfer(vecs[v].val, vecs[v].dpv);
      for (int d = 0; d < 4; d++) begin
        push(4'(~(4'b0001 << d)), vecs[v].seg[d],
             ~vecs[v].dpv[d]);
      end
      for (int k = 0; k < 4; k++) advance();
    end

    // second offer while pending is full
    xfer(16'h3456, 4'b0001);
    value_in = 16'h9876;
    dp_in = 4'b0000;
    value_valid = 1'b1;
    step();
    chk("ready_full_block", value_ready, 1'b0);
    push(4'hE, 7'h02, 1'b0);
    tick_pulse();
    n = 0;
    while (!value_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_reopen", value_ready, 1'b1);
    step();
    chk("v2_accepted", value_ready, 1'b0);
    value_valid = 1'b0;
    steps(5);
    push(4'hD, 7'h12, 1'b1);
    push(4'hB, 7'h19, 1'b1);
    push(4'h7, 7'h30, 1'b1);
    push(4'hE, 7'h02, 1'b1);
    push(4'hD, 7'h78, 1'b1);
    for (int i = 0; i < 5; i++) advance();

    // two rises inside one gap -> single advance
    push(4'hB, 7'h00, 1'b1);
    tick = 1'b1;
    step();
    chk("dbl_p1_lit", anode, 4'hD);
    tick = 1'b0;
    step();
    chk("dbl_gap1", anode, 4'hF);
    tick = 1'b1;
    step();
    chk("dbl_gap2", anode, 4'hF);
    tick = 1'b0;
    step();
    chk("dbl_next", anode, 4'hB);
    steps(8);
    chk("dbl_no_second", anode, 4'hB);

    // disable for 10 ticks, handshake still live
    enable = 1'b0;
    step();
    chk("dis_anode", anode, 4'hF);
    chk("dis_segment", segment, 7'h7F);
    chk("dis_dp", dp, 1'b1);
    xfer(16'h0070, 4'b0000);
    chk("ready_while_disabled", value_ready, 1'b0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick = 1'b1;
      step();
      if ({anode, segment, dp} !== 12'hFFF) bad++;
      tick = 1'b0;
      step();
      if ({anode, segment, dp} !== 12'hFFF) bad++;
    end
    chk("dis_outputs_idle", bad, 0);
    push(4'hB, 7'h00, 1'b1);
    enable = 1'b1;
    steps(3);
    chk("resume_idx", anode, 4'hB);
    push(4'h7, 7'h10, 1'b1);
    advance();

    // 0x0070: leading-zero handling
    push(4'hE, 7'h40, 1'b1);
    push(4'hD, 7'h78, 1'b1);
    push(4'hB, ZHI, 1'b1);
    push(4'h7, ZHI, 1'b1);
    for (int i = 0; i < 4; i++) advance();

    steps(3);
    chk("frame_done_count", fd_count, 9);
    chk("scan_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan_driver.md
Name: seven_segment_scan_driver

Overview:
- Time-multiplexed scan driver for a common-anode multi-digit seven-segment display.
- Consumes the square-wave tick produced by the display tick generator and advances one digit per tick rising edge.
- Inserts a dead-time gap between digits to suppress ghosting.
- Accepts new display values through a valid/ready handshake and applies them only at frame boundaries, so a frame never shows mixed old and new digits.

Parameters:
- NUM_DIGITS, 4: number of digits; value width is 4*NUM_DIGITS.
- BLANK_CYCLES, 16: clock cycles with all anodes off between digits; 0 is treated as 1.
- ACTIVE_LOW, 1: 1 means anode and segment outputs drive low to light, 0 means drive high to light.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  square wave from the tick generator (same clock domain); each rising edge is one scan step.
- enable  in  1  0 turns all anodes off and holds scan state.
- value_in  in  4*NUM_DIGITS  hex nibbles; nibble 0 is the rightmost digit.
- dp_in  in  NUM_DIGITS  decimal-point enables, bit i belongs to digit i.
- value_valid  in  1  value_in and dp_in are offered.
- value_ready  out  1  pending slot is empty; a transfer happens when valid and ready are both high.
- anode  out  NUM_DIGITS  digit select, one-hot when active, polarity set by ACTIVE_LOW.
- segment  out  7  segments {g,f,e,d,c,b,a}, polarity set by ACTIVE_LOW.
- dp  out  1  decimal point, polarity set by ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Tick edge detect: tick_q is registered; tick_rise = tick & ~tick_q. tick_q resets to 0.
- States: GAP and SHOW.
  - GAP: all anodes inactive; gap_cnt counts up to max(BLANK_CYCLES,1).
  - On GAP exit: idx advances, wrapping from NUM_DIGITS-1 to 0, and the state goes to SHOW.
  - SHOW: the anode for idx is active; segments decode the selected display nibble; dp = display_dp[idx]. On tick_rise the state goes to GAP and gap_cnt clears.
  - tick_rise during GAP is ignored and not queued.
- Frame boundary: the idx wrap to 0.
  - That cycle: frame_done=1.
  - If the pending slot is full, display_value/display_dp load from pending and pending empties.
- Handshake:
  - value_ready = !pending_full.
  - On transfer, the pending slot captures value_in and dp_in.
  - value_ready stays low on the commit cycle and rises the following cycle.
  - value_in changing while value_ready is low has no effect.
- enable=0:
  - All anodes, segments and dp are inactive.
  - State, idx and gap_cnt are held.
  - The handshake stays operational.
  - Re-enable resumes in the held state.
- Outputs are registered: anode, segment and dp reflect the state one clock after the state register changes.
- Reset (synchronous, active-high):
  - State=GAP, gap_cnt=0, idx=NUM_DIGITS-1, so the first GAP exit wraps to digit 0, commits pending and pulses frame_done.
  - display_value=0, display_dp=0, pending empty, value_ready=1.
  - anode, segment and dp inactive; frame_done=0.
  - Reset mid-GAP or mid-SHOW discards a pending value.
- Decode is hex 0-F, standard glyphs: 0=0111111, 1=0000110, 8=1111111, F=1110001 (active-high {g..a}), then inverted if ACTIVE_LOW.

Optional Feature:
- Macro SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits above the most-significant non-zero nibble show blank segments; digit 0 always shows.
  - dp is not suppressed.
  - The anode still scans, so timing is unchanged.
- Undefined: all digits always show, including zeros.

Decomposition:
- Package seven_seg_pkg holds:
  - the state encoding constants (GAP, SHOW);
  - the 16-entry hex-to-segment constant table;
  - the segment bit-order constants.
- One combinational sub-module: seven_segment_hex_decoder (4-bit nibble in, 7-bit active-high segments out, blank input forces all off).
- Polarity inversion happens in the parent.

Test Plan:
Bench uses NUM_DIGITS=4, BLANK_CYCLES=2, ACTIVE_LOW=1, with tick driven manually.
- Reset, then wait 3 clocks -> anode=1110, segment=1000000 (digit 0 shows "0"), frame_done pulsed once, value_ready=1.
- Transfer value 0x12AF with dp=0100 mid-frame, then 4 tick rises -> old digits finish the frame; after the wrap, the anode sequence 1110/1101/1011/0111 shows F, A, 2, 1 with dp active only while anode=1011; value_ready is 0 until the commit, then returns to 1.
- Offer a second value while pending is full -> value_ready=0, no capture; the first pending value is displayed after the wrap and the second is accepted on the following cycle.
- Two tick rises inside one GAP -> exactly one digit advance; anode=1111 for 2 cycles between digits.
- enable=0 for 10 ticks, then 1 -> outputs all high while disabled; scan resumes at the held idx.
- Macro defined with value 0x0070 -> digits 3 and 2 blank (segment=1111111), digit 1 shows "7", digit 0 shows "0"; macro undefined -> digits 3 and 2 show "0".
